// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the Y86-64 pipeline control unit.
// Holds the instruction codes, status codes and the "no register" id that the
// hazard logic decodes, plus a helper that flags exception status values.
package pipe_hazard_ctrl_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Register id meaning "no register"
    localparam logic [3:0] RNONE = 4'hF;

    // Status codes
    localparam logic [2:0] STAT_BUBBLE = 3'd0;
    localparam logic [2:0] SAOK        = 3'd1;
    localparam logic [2:0] SADR        = 3'd2;
    localparam logic [2:0] SINS        = 3'd3;
    localparam logic [2:0] SHLT        = 3'd4;

    // True for the status values that must stop the machine.
    function automatic logic is_exc(input logic [2:0] stat);
        return (stat == SADR) || (stat == SINS) || (stat == SHLT);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating event counter.
// Ports:
//   clk_i    clock
//   rst_n_i  asynchronous active-low reset, clears the count
//   en_i     counting window (e.g. "FSM is in the right state")
//   inc_i    event seen this cycle
//   cnt_o    current count; sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             en_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else if (en_i && inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/bubble control for the 5-stage Y86-64 pipeline.
// Ports:
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   D/E/M_icode_i, d_src*_i,
//   E_dstM_i, e_Cnd_i         hazard detection inputs
//   m_stat_i, W_stat_i        memory-stage / W-register status
//   m_mem_req_i, dmem_ack_i   data-memory handshake
//   *_stall_o, *_bubble_o     per-register controls, combinational
//   cpu_halted_o              registered, set once the machine halts
//   mem_timeout_o             registered, sticky data-memory timeout flag
//   *_cnt_o                   saturating performance counters
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [3:0]       D_icode_i,
    input  logic [3:0]       d_srcA_i,
    input  logic [3:0]       d_srcB_i,
    input  logic [3:0]       E_icode_i,
    input  logic [3:0]       E_dstM_i,
    input  logic             e_Cnd_i,
    input  logic [3:0]       M_icode_i,
    input  logic [2:0]       m_stat_i,
    input  logic [2:0]       W_stat_i,
    input  logic             m_mem_req_i,
    input  logic             dmem_ack_i,
    output logic             F_stall_o,
    output logic             D_stall_o,
    output logic             D_bubble_o,
    output logic             E_stall_o,
    output logic             E_bubble_o,
    output logic             M_stall_o,
    output logic             M_bubble_o,
    output logic             W_stall_o,
    output logic             W_bubble_o,
    output logic             cpu_halted_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] loaduse_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o,
    output logic [CNT_W-1:0] memwait_cnt_o
);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StMemWait = 2'd1,
        StHalted  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d, wait_inc;
    logic        halted_q, timeout_q, timeout_d;

    logic lu, ret_h, mp, exc_m, exc_w, dmem_wait;
    logic f_stall, d_stall, d_bubble, e_stall, e_bubble;
    logic m_stall, m_bubble, w_stall, w_bubble;

    assign lu = ((E_icode_i == IMRMOVQ) || (E_icode_i == IPOPQ)) && (E_dstM_i != RNONE) &&
                ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
    assign ret_h     = (D_icode_i == IRET) || (E_icode_i == IRET) || (M_icode_i == IRET);
    assign mp        = (E_icode_i == IJXX) && !e_Cnd_i;
    assign exc_m     = is_exc(m_stat_i);
    assign exc_w     = is_exc(W_stat_i);
    assign dmem_wait = m_mem_req_i && !dmem_ack_i;

    always_comb begin
        f_stall    = 1'b0;
        d_stall    = 1'b0;
        d_bubble   = 1'b0;
        e_stall    = 1'b0;
        e_bubble   = 1'b0;
        m_stall    = 1'b0;
        m_bubble   = 1'b0;
        w_stall    = 1'b0;
        w_bubble   = 1'b0;
        state_d    = state_q;
        wait_inc   = (wait_cnt_q == 16'hFFFF) ? wait_cnt_q : wait_cnt_q + 16'd1;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;

        unique case (state_q)
            StRun: begin
                if (dmem_wait) begin
                    // Freeze F..M while the access is outstanding; W drains.
                    {f_stall, d_stall, e_stall, m_stall} = 4'b1111;
                    w_bubble = 1'b1;
                end else begin
                    f_stall  = lu | ret_h;
                    d_stall  = lu;
                    d_bubble = mp | (ret_h & ~lu);
                    e_bubble = mp | lu;
                    m_bubble = exc_m | exc_w;
                    w_stall  = exc_w;
                end
                // An exception reaching W outranks a memory wait.
                if (exc_w) begin
                    state_d = StHalted;
                end else if (dmem_wait) begin
                    state_d = StMemWait;
                end
            end
            StMemWait: begin
                // Stall is still held on the ack cycle; M captures the data at the edge.
                {f_stall, d_stall, e_stall, m_stall} = 4'b1111;
                w_bubble   = 1'b1;
                wait_cnt_d = dmem_ack_i ? 16'd0 : wait_inc;
                if (32'(wait_inc) >= MEM_TIMEOUT) begin
                    timeout_d = 1'b1;
                end
                if (dmem_ack_i) begin
                    state_d = StRun;
                end
            end
            StHalted: begin
                {f_stall, d_stall, e_stall, m_stall, w_stall} = 5'b11111;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= StRun;
            wait_cnt_q <= 16'd0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            halted_q   <= (state_d == StHalted);
            timeout_q  <= timeout_d;
        end
    end

    // Stall always wins over bubble on the same register.
    assign F_stall_o  = f_stall;
    assign D_stall_o  = d_stall;
    assign D_bubble_o = d_bubble & ~d_stall;
    assign E_stall_o  = e_stall;
    assign E_bubble_o = e_bubble & ~e_stall;
    assign M_stall_o  = m_stall;
    assign M_bubble_o = m_bubble & ~m_stall;
    assign W_stall_o  = w_stall;
    assign W_bubble_o = w_bubble & ~w_stall;

    assign cpu_halted_o  = halted_q;
    assign mem_timeout_o = timeout_q;

    sat_counter #(.CNT_W(CNT_W)) u_loaduse_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (state_q == StRun),
        .inc_i   (lu),
        .cnt_o   (loaduse_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (state_q == StRun),
        .inc_i   (mp),
        .cnt_o   (mispred_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_memwait_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (state_q == StMemWait),
        .inc_i   (1'b1),
        .cnt_o   (memwait_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed steps followed by random
// epochs, every cycle compared against a behavioural model of the control rules.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W       = 8;
    localparam int MEM_TIMEOUT = 3;
    localparam int CMAX        = 255;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [2:0] S_BUB    = 3'd0;
    localparam logic [2:0] S_AOK    = 3'd1;
    localparam logic [2:0] S_ADR    = 3'd2;
    localparam logic [2:0] S_INS    = 3'd3;
    localparam logic [2:0] S_HLT    = 3'd4;

    logic clk, rst_n;
    logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
    logic       e_Cnd, m_mem_req, dmem_ack;
    logic [2:0] m_stat, W_stat;
    logic F_stall, D_stall, D_bubble, E_stall, E_bubble, M_stall, M_bubble, W_stall, W_bubble;
    logic cpu_halted, mem_timeout;
    logic [CNT_W-1:0] loaduse_cnt, mispred_cnt, memwait_cnt;
    logic [8:0] ctrl;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .D_icode_i     (D_icode),
        .d_srcA_i      (d_srcA),
        .d_srcB_i      (d_srcB),
        .E_icode_i     (E_icode),
        .E_dstM_i      (E_dstM),
        .e_Cnd_i       (e_Cnd),
        .M_icode_i     (M_icode),
        .m_stat_i      (m_stat),
        .W_stat_i      (W_stat),
        .m_mem_req_i   (m_mem_req),
        .dmem_ack_i    (dmem_ack),
        .F_stall_o     (F_stall),
        .D_stall_o     (D_stall),
        .D_bubble_o    (D_bubble),
        .E_stall_o     (E_stall),
        .E_bubble_o    (E_bubble),
        .M_stall_o     (M_stall),
        .M_bubble_o    (M_bubble),
        .W_stall_o     (W_stall),
        .W_bubble_o    (W_bubble),
        .cpu_halted_o  (cpu_halted),
        .mem_timeout_o (mem_timeout),
        .loaduse_cnt_o (loaduse_cnt),
        .mispred_cnt_o (mispred_cnt),
        .memwait_cnt_o (memwait_cnt)
    );

    assign ctrl = {F_stall, D_stall, D_bubble, E_stall, E_bubble,
                   M_stall, M_bubble, W_stall, W_bubble};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: machine mode as flags plus plain integer counts.
    bit m_halted, m_waiting, m_timeout;
    int m_run, m_lu_cnt, m_mp_cnt, m_mw_cnt;
    int vectors, miscompares;

    function automatic bit is_exc(input logic [2:0] s);
        return (s == S_ADR) || (s == S_INS) || (s == S_HLT);
    endfunction

    function automatic bit h_lu();
        return ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) && (E_dstM != R_NONE) &&
               ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    endfunction

    function automatic bit h_mp();
        return (E_icode == I_JXX) && !e_Cnd;
    endfunction

    function automatic logic [8:0] exp_ctrl();
        bit lu, rt, mp;
        logic fs, ds, db, es, eb, ms, mb, ws, wb;
        lu = h_lu();
        mp = h_mp();
        rt = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        {fs, ds, db, es, eb, ms, mb, ws, wb} = '0;
        if (m_halted) begin
            {fs, ds, es, ms, ws} = 5'b11111;
        end else if (m_waiting || (m_mem_req && !dmem_ack)) begin
            {fs, ds, es, ms} = 4'b1111;
            wb = 1'b1;
        end else begin
            fs = lu | rt;
            ds = lu;
            db = mp | (rt & ~lu);
            eb = mp | lu;
            mb = is_exc(m_stat) | is_exc(W_stat);
            ws = is_exc(W_stat);
        end
        return {fs, ds, db, es, eb, ms, mb, ws, wb};
    endfunction

    task automatic model_reset();
        m_halted = 0; m_waiting = 0; m_timeout = 0;
        m_run = 0; m_lu_cnt = 0; m_mp_cnt = 0; m_mw_cnt = 0;
    endtask

    // Advance the model by one clock edge using this cycle's inputs.
    task automatic model_edge();
        if (m_halted) return;
        if (m_waiting) begin
            if (m_mw_cnt < CMAX) m_mw_cnt++;
            if (m_run < 65535) m_run++;
            if (m_run >= MEM_TIMEOUT) m_timeout = 1;
            if (dmem_ack) begin
                m_waiting = 0;
                m_run = 0;
            end
        end else begin
            if (h_lu() && m_lu_cnt < CMAX) m_lu_cnt++;
            if (h_mp() && m_mp_cnt < CMAX) m_mp_cnt++;
            if (is_exc(W_stat)) m_halted = 1;
            else if (m_mem_req && !dmem_ack) m_waiting = 1;
        end
    endtask

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check(input string tag);
        logic [8:0] e;
        e = exp_ctrl();
        vectors++;
        assert (ctrl === e) else begin
            miscompares++;
            $error("FAIL %s ctrl observed %b expected %b", tag, ctrl, e);
        end
        expect_eq({tag, ".halted"},  32'(cpu_halted),  32'(m_halted));
        expect_eq({tag, ".timeout"}, 32'(mem_timeout), 32'(m_timeout));
        expect_eq({tag, ".lu_cnt"},  32'(loaduse_cnt), 32'(m_lu_cnt));
        expect_eq({tag, ".mp_cnt"},  32'(mispred_cnt), 32'(m_mp_cnt));
        expect_eq({tag, ".mw_cnt"},  32'(memwait_cnt), 32'(m_mw_cnt));
    endtask

    // Called at a negedge with inputs set; returns at the following negedge.
    task automatic step(input string tag);
        #1;
        check(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        D_icode = I_NOP; d_srcA = R_NONE; d_srcB = R_NONE;
        E_icode = I_NOP; E_dstM = R_NONE; e_Cnd = 1'b1; M_icode = I_NOP;
        m_stat = S_AOK; W_stat = S_AOK; m_mem_req = 1'b0; dmem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [3:0] rnd_reg();
        return ($urandom_range(0, 4) == 4) ? R_NONE : 4'($urandom_range(0, 3));
    endfunction

    function automatic logic [3:0] rnd_icode();
        case ($urandom_range(0, 5))
            0: return I_MRMOVQ;
            1: return I_POPQ;
            2: return I_JXX;
            3: return I_RET;
            4: return I_NOP;
            default: return 4'($urandom_range(0, 11));
        endcase
    endfunction

    task automatic randomize_inputs();
        D_icode   = rnd_icode();
        E_icode   = rnd_icode();
        M_icode   = rnd_icode();
        d_srcA    = rnd_reg();
        d_srcB    = rnd_reg();
        E_dstM    = rnd_reg();
        e_Cnd     = 1'($urandom_range(0, 1));
        m_stat    = 3'($urandom_range(0, 4));
        W_stat    = ($urandom_range(0, 63) == 0) ? 3'($urandom_range(2, 4))
                                                 : (($urandom_range(0, 1) == 0) ? S_AOK : S_BUB);
        m_mem_req = ($urandom_range(0, 2) == 0);
        dmem_ack  = 1'($urandom_range(0, 1));
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        idle();
        rst_n = 1'b1;
        @(negedge clk);
        do_reset();
        step("idle");

        // Load/use on srcA
        E_icode = I_MRMOVQ; E_dstM = 4'h3; d_srcA = 4'h3;
        #1;
        expect_eq("lu.F_stall", 32'(F_stall), 1);
        expect_eq("lu.D_bubble", 32'(D_bubble), 0);
        step("lu");
        idle();
        step("lu_after");
        expect_eq("lu.count", 32'(loaduse_cnt), 1);

        // ret in D, then in M, then with a load/use
        D_icode = I_RET;
        #1;
        expect_eq("retD.D_bubble", 32'(D_bubble), 1);
        step("retD");
        idle(); M_icode = I_RET;
        step("retM");
        E_icode = I_POPQ; E_dstM = 4'h2; d_srcB = 4'h2;
        #1;
        expect_eq("ret_lu.D_bubble", 32'(D_bubble), 0);
        expect_eq("ret_lu.D_stall", 32'(D_stall), 1);
        step("ret_lu");

        // Mispredict
        idle(); E_icode = I_JXX; e_Cnd = 1'b0;
        #1;
        expect_eq("mp.F_stall", 32'(F_stall), 0);
        step("mp");
        idle(); E_icode = I_JXX; e_Cnd = 1'b1;
        step("jxx_taken");

        // Memory wait: 4 cycles without ack, then ack
        idle(); m_mem_req = 1'b1;
        for (int i = 0; i < 4; i++) step("memwait");
        dmem_ack = 1'b1;
        step("memack");
        idle();
        step("after_wait");
        expect_eq("memwait.count", 32'(memwait_cnt), 4);
        expect_eq("memwait.timeout", 32'(mem_timeout), 1);

        // Asynchronous reset while in MEM_WAIT, away from any clock edge
        m_mem_req = 1'b1;
        step("wait2a");
        step("wait2b");
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Counter saturation
        E_icode = I_MRMOVQ; E_dstM = 4'h1; d_srcA = 4'h1;
        for (int i = 0; i < 260; i++) step("lu_sat");
        expect_eq("lu.saturated", 32'(loaduse_cnt), CMAX);
        idle();
        do_reset();

        // Exception in W halts the machine; hazards afterwards do nothing
        W_stat = S_ADR;
        #1;
        expect_eq("exc.W_stall", 32'(W_stall), 1);
        expect_eq("exc.M_bubble", 32'(M_bubble), 1);
        step("exc");
        idle();
        expect_eq("exc.halted", 32'(cpu_halted), 1);
        for (int i = 0; i < 20; i++) begin
            randomize_inputs();
            step("halted");
        end

        // Random epochs
        for (int ep = 0; ep < 8; ep++) begin
            idle();
            do_reset();
            for (int i = 0; i < 300; i++) begin
                randomize_inputs();
                step("rand");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
